// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the buffered UART transmitter:
//               serializer state encoding, default bit period and frame
//               lengths (in bit periods).
// Config      : UART_TX_PARITY_EN selects the 8E1 frame in the users.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;

  // Frame lengths in bit periods: start + 8 data (+ parity) + stop
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;
  localparam int DATA_BITS      = FRAME_BITS_8N1 - 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-in first-out buffer with registered
//               full/empty flags that reflect the occupancy after each edge.
//               Writes while full are dropped, even with a concurrent read.
// Ports       : clk, reset (async, active high)
//               i_wr_en/i_wr_data  - push interface
//               i_rd_en/o_rd_data  - pop interface, data valid while !o_empty
//               o_full, o_empty    - registered occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W:0]   w_count_nxt;

  // Gate on the registered flags so a full FIFO ignores a write even when a
  // read frees a slot in the same cycle.
  assign w_wr = i_wr_en & ~r_full;
  assign w_rd = i_rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : Byte FIFO feeding an 8N1 UART serializer (8E1 when the
//               UART_TX_PARITY_EN macro is defined).
// Ports       : clk, reset (async, active high)
//               wr_en, wr_data     - byte push from the messenger
//               full, UART_empty   - registered FIFO flags
//               tx_busy            - serializer not idle
//               tx                 - registered serial line, idle high
// Config      : `define UART_TX_PARITY_EN to add an even parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       UART_empty,
  output logic       tx_busy,
  output logic       tx
);

  localparam int TIMER_W = 16;

  tx_state_e          r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic               w_pop;
  logic               w_bit_done;
  logic [7:0]         w_fifo_data;
  logic               w_empty;

  sync_fifo #(
    .DATA_W (8),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (full),
    .o_empty   (w_empty)
  );

  // The serializer only takes a byte while idle, so the pop never needs to
  // wait on anything but the empty flag.
  assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
  assign w_bit_done = (r_timer == TIMER_W'(CLKS_PER_BIT - 1));

  // tx is registered and loaded with the level of the state being entered,
  // so each bit appears on the line in the same cycle the state changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_fifo_data;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_fifo_data;
`endif
            r_state   <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              // Bit 0 of the shift register is always the bit on the line.
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_timer <= '0;
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign tx_busy    = (r_state != ST_IDLE);
  assign UART_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4).
//               Expected bytes are queued when written and compared bit by
//               bit, cycle by cycle, by a serial-line decoder. Define
//               UART_TX_PARITY_EN for the 8E1 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int AW  = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int NBITS = FRAME_BITS_8E1;
`else
  localparam bit PAR   = 1'b0;
  localparam int NBITS = FRAME_BITS_8N1;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       UART_empty;
  logic       tx_busy;
  logic       tx;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         starts[$];
  int         cyc      = 0;
  bit         dec_busy = 1'b0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .UART_empty (UART_empty),
    .tx_busy    (tx_busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected line level for bit period k of a frame carrying byte b.
  function automatic logic lvl(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Serial decoder: every cycle of every frame is compared against the
  // oldest expected byte. A reset aborts the frame in progress.
  initial begin : decoder
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        dec_busy = 1'b1;
        starts.push_back(cyc);
        chk("frame_expected", 32'(sb.size() != 0), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        for (int j = 1; j < FRAME; j++) begin
          @(negedge clk);
          if (reset) break;
          chk($sformatf("frame_%02h_bit%0d", e, j / CPB), 32'(tx), 32'(lvl(e, j / CPB)));
        end
        dec_busy = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(sb.size() == 0 && !dec_busy && UART_empty && !tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  // One byte into an idle, empty block: start edge two cycles after the
  // write, empty for one cycle, busy for a whole frame.
  task automatic single_frame(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    wr_en = 1'b1; wr_data = b; sb.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
    chk("empty_after_write", 32'(UART_empty), 32'd0);
    chk("tx_high_n_plus_1", 32'(tx), 32'd1);
    chk("busy_n_plus_1", 32'(tx_busy), 32'd0);
    @(negedge clk);
    chk("start_n_plus_2", 32'(tx), 32'd0);
    chk("empty_after_pop", 32'(UART_empty), 32'd1);
    while (tx_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(FRAME));
    chk("tx_idle_after_frame", 32'(tx), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int low;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(UART_empty), 32'd1);
    reset = 1'b0;

    // Single byte 'A'
    single_frame(8'h41);
    wait_drain("drain_41");

    // Fill to full while the first byte is on the line; 8'hEE lands on full.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 16) chk("full_after_16_writes", 32'(full), 32'd0);
      if (i == 17) chk("full_after_17_writes", 32'(full), 32'd1);
      wr_en = 1'b1;
      wr_data = (i < 17) ? 8'(8'h30 + i) : 8'hEE;
      if (i < 17) sb.push_back(8'(8'h30 + i));
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("full_after_drop", 32'(full), 32'd1);

    // Write while full in the cycle the serializer pops: dropped, count 15.
    n = 0;
    while (tx_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_pop", 32'(n < 200), 32'd1);
    chk("full_at_pop", 32'(full), 32'd1);
    wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    chk("full_after_pop_drop", 32'(full), 32'd0);
    chk("empty_after_pop_drop", 32'(UART_empty), 32'd0);
    // One more byte must exactly refill the FIFO.
    wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
    @(negedge clk);
    wr_en = 1'b0;
    chk("full_after_refill", 32'(full), 32'd1);
    wait_drain("drain_fill");

    // Back-to-back bytes: one idle cycle between frames.
    starts.delete();
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h48; sb.push_back(8'h48);
    @(negedge clk);
    wr_data = 8'h69; sb.push_back(8'h69);
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (starts.size() < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("two_frames_seen", 32'(starts.size() >= 2), 32'd1);
    if (starts.size() >= 2) chk("frame_period", 32'(starts[1] - starts[0]), 32'(FRAME + 1));
    wait_drain("drain_pair");

    // Reset in the third data bit with five bytes queued.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i); sb.push_back(8'(8'hC0 + i));
    end
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_frame_started", 32'(tx), 32'd0);
    repeat (13) @(negedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_empty", 32'(UART_empty), 32'd1);
    chk("abort_full", 32'(full), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    low = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("no_start_after_reset", 32'(low), 32'd0);
    chk("empty_after_reset", 32'(UART_empty), 32'd1);

    // First write after reset follows the normal latency.
    single_frame(8'h5A);
    wait_drain("drain_5a");

`ifdef UART_TX_PARITY_EN
    single_frame(8'h07);
    wait_drain("drain_07");
    single_frame(8'h03);
    wait_drain("drain_03");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
